// File: rtl/bp_nonsynth_io_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_nonsynth_io_cmd_arbiter_pkg
// Brief  : Shared types and sizing helpers for the nonsynth I/O command arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package bp_nonsynth_io_cmd_arbiter_pkg;

  typedef enum logic [0:0] {
    e_arb_idle = 1'b0,
    e_arb_lock = 1'b1
  } bp_io_arb_state_e;

  localparam int c_default_msg_width   = 64;
  localparam int c_default_max_credits = 4;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int bsg_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Pointer width for an n-entry storage; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_nonsynth_io_cmd_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module : bp_nonsynth_io_cmd_arbiter_tag_fifo
// Brief  : One-bit-wide, els_p-deep FIFO holding the issuing requester of
//          each outstanding command.
// Rev    : 1.0  initial release
// ============================================================================
module bp_nonsynth_io_cmd_arbiter_tag_fifo
  import bp_nonsynth_io_cmd_arbiter_pkg::*;
#(
  parameter int els_p = c_default_max_credits
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic data_i,
  input  logic v_i,
  input  logic yumi_i,
  output logic data_o,
  output logic v_o
);

  localparam int c_ptr_w = ptr_width(els_p);
  localparam int c_depth = 1 << c_ptr_w;
  localparam int c_cnt_w = bsg_width(els_p);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(els_p - 1);

  logic [c_depth-1:0] r_mem;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_cnt_w-1:0] r_count;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // The credit budget upstream keeps pushes from ever reaching a full FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mem   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (v_i) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (yumi_i) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({v_i, yumi_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o = r_mem[r_rptr];
  assign v_o    = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/bp_nonsynth_io_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bp_nonsynth_io_cmd_arbiter
// Brief  : Shares one nonsynth I/O command/response channel between the NBF
//          loader (requester 0) and a host/debug source (requester 1).
// Rev    : 1.0  initial release
// ============================================================================
module bp_nonsynth_io_cmd_arbiter
  import bp_nonsynth_io_cmd_arbiter_pkg::*;
#(
  parameter int cce_mem_msg_width_p = c_default_msg_width,
  parameter int max_credits_p       = c_default_max_credits,
  parameter int fixed_priority_p    = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             freeze_i,

  input  logic [2*cce_mem_msg_width_p-1:0] req_cmd_i,
  input  logic [1:0]                       req_cmd_v_i,
  output logic [1:0]                       req_cmd_yumi_o,

  output logic [cce_mem_msg_width_p-1:0]   req_resp_o,
  output logic [1:0]                       req_resp_v_o,
  input  logic [1:0]                       req_resp_ready_i,

  output logic [cce_mem_msg_width_p-1:0]   io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,

  input  logic [cce_mem_msg_width_p-1:0]   io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,

  output logic                             credits_empty_o,
  output logic                             idle_o
);

  localparam int c_w      = cce_mem_msg_width_p;
  localparam int c_cred_w = bsg_width(max_credits_p);

  bp_io_arb_state_e          r_state;
  bp_io_arb_state_e          w_state_n;
  logic                      r_grant;
  logic                      r_last_grant;
  logic [c_w-1:0]            r_cmd;
  logic [c_cred_w-1:0]       r_count;

  logic                      w_winner;
  logic                      w_grant_start;
  logic                      w_cmd_fire;
  logic                      w_resp_fire;
  logic                      w_credits_full;
  logic                      w_credits_empty;
  logic                      w_tag_head;
  logic                      w_tag_v;

  assign w_credits_full  = (r_count == c_cred_w'(max_credits_p));
  assign w_credits_empty = (r_count == '0);

  if (fixed_priority_p != 0) begin : g_fixed_priority
    assign w_winner = ~req_cmd_v_i[0];
  end else begin : g_round_robin
    // On a tie the requester that did not win last time goes next.
    assign w_winner = (&req_cmd_v_i) ? ~r_last_grant : req_cmd_v_i[1];
  end

  always_comb begin
    w_state_n      = r_state;
    w_grant_start  = 1'b0;
    io_cmd_v_o     = 1'b0;
    req_cmd_yumi_o = 2'b00;
    w_cmd_fire     = 1'b0;
    case (r_state)
      e_arb_idle: begin
        if (!freeze_i && !w_credits_full && (|req_cmd_v_i)) begin
          w_grant_start = 1'b1;
          w_state_n     = e_arb_lock;
        end
      end
      e_arb_lock: begin
        io_cmd_v_o = req_cmd_v_i[r_grant] & ~w_credits_full;
        w_cmd_fire = io_cmd_v_o & io_cmd_yumi_i;
        if (w_cmd_fire) begin
          req_cmd_yumi_o[r_grant] = 1'b1;
          w_state_n               = e_arb_idle;
        end
      end
      default: w_state_n = e_arb_idle;
    endcase
  end

  // The granted command is captured so io_cmd_o stays stable for the lock.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= e_arb_idle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cmd        <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_grant_start) begin
        r_grant <= w_winner;
        r_cmd   <= w_winner ? req_cmd_i[c_w +: c_w] : req_cmd_i[0 +: c_w];
      end
      if (w_cmd_fire) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign io_cmd_o = r_cmd;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else begin
      case ({w_cmd_fire, w_resp_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  bp_nonsynth_io_cmd_arbiter_tag_fifo #(
    .els_p(max_credits_p)
  ) u_tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (r_grant),
    .v_i    (w_cmd_fire),
    .yumi_i (w_resp_fire),
    .data_o (w_tag_head),
    .v_o    (w_tag_v)
  );

  // Responses return in issue order, so the FIFO head names the owner.
  assign req_resp_o      = io_resp_i;
  assign req_resp_v_o    = (io_resp_v_i & w_tag_v) ? (w_tag_head ? 2'b10 : 2'b01) : 2'b00;
  assign io_resp_ready_o = w_tag_v & req_resp_ready_i[w_tag_head];
  assign w_resp_fire     = io_resp_v_i & io_resp_ready_o;

  assign credits_empty_o = w_credits_empty;
  assign idle_o          = w_credits_empty & (r_state == e_arb_idle) & ~(|req_cmd_v_i);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (r_state == e_arb_lock) begin
        assert (req_cmd_v_i[r_grant])
          else $error("arbiter: granted requester dropped valid while locked");
      end
      assert (!io_cmd_yumi_i || io_cmd_v_o)
        else $error("arbiter: io_cmd_yumi_i without io_cmd_v_o");
      assert (!io_resp_v_i || w_tag_v)
        else $error("arbiter: io response with no command outstanding");
    end
  end
`endif

endmodule
`default_nettype wire
